// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command handshake bundle for the PS/2 host transmitter
//
// Purpose: groups the command request/acknowledge and status signals between a
// command source (master) and the PS/2 host transmitter (slave).
// Signals:
//   cmd_data  [7:0]  command byte to send to the keyboard
//   cmd_valid        command request, taken when cmd_ready is high
//   cmd_ready        transmitter idle and able to take a command
//   busy             transmitter engaged in a transfer
//   done             one-cycle pulse: byte sent and ACK received
//   err              one-cycle pulse: NACK or timeout
interface ps2_host_tx_if;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output cmd_data, cmd_valid,
    input  cmd_ready, busy, done, err
  );

  modport slave (
    input  cmd_data, cmd_valid,
    output cmd_ready, busy, done, err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device byte transmitter (inhibit, RTS, frame, ACK)
//
// Purpose: sends one command byte to a PS/2 device. The host pulls the clock low
// to inhibit, issues request-to-send, then shifts out data on each device clock
// falling edge and checks the device ACK.
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   cmd          command handshake (slave side of ps2_host_tx_if)
//   ps2_clk_i    raw PS/2 clock line level
//   ps2_data_i   raw PS/2 data line level
//   ps2_clk_oe   1 = pull PS/2 clock low, 0 = release
//   ps2_data_oe  1 = pull PS/2 data low, 0 = release
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic         clk,
  input  logic         rst,
  ps2_host_tx_if.slave cmd,
  input  logic         ps2_clk_i,
  input  logic         ps2_data_i,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);

  // One counter serves both the inhibit interval and the edge-to-edge timeout.
  localparam int TMR_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] INH_LAST = TMR_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_VAL  = TMR_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             clk_meta;
  logic             clk_sync;
  logic             clk_last;
  logic             data_meta;
  logic             data_sync;
  logic [TMR_W-1:0] tmr;
  logic [3:0]       bit_idx;
  logic [9:0]       frame;
  logic             fall;
  logic             accept;
  logic             inh_last;
  logic             line_idle;
  logic             active;
  logic             timeout;
  logic             nack;

  // Line synchronizers; reset to the idle (released) level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_last  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_i;
      clk_sync  <= clk_meta;
      clk_last  <= clk_sync;
      data_meta <= ps2_data_i;
      data_sync <= data_meta;
    end
  end

  assign fall      = clk_last & ~clk_sync;
  assign accept    = cmd.cmd_valid && (state == S_IDLE);
  assign inh_last  = (state == S_INHIBIT) && (tmr == INH_LAST);
  assign line_idle = clk_sync & data_sync;
  assign active    = (state == S_RTS) || (state == S_SEND) ||
                     (state == S_ACK) || (state == S_WAIT_IDLE);
  // A falling edge in the same cycle restarts the count, and a completed
  // handshake in WAIT_IDLE wins, so done and err can never coincide.
  assign timeout   = active && (tmr == TMO_VAL) && !fall &&
                     !((state == S_WAIT_IDLE) && line_idle);
  assign nack      = (state == S_ACK) && fall && data_sync;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (accept) state_nx = S_INHIBIT;
      S_INHIBIT:   if (inh_last) state_nx = S_RTS;
      S_RTS: begin
        if (timeout)   state_nx = S_IDLE;
        else if (fall) state_nx = S_SEND;
      end
      // Falls in SEND present bits 1..8; the fall that presents the stop bit
      // (line released) moves on to ACK.
      S_SEND: begin
        if (timeout)                       state_nx = S_IDLE;
        else if (fall && bit_idx == 4'd8)  state_nx = S_ACK;
      end
      S_ACK: begin
        if (timeout)   state_nx = S_IDLE;
        else if (fall) state_nx = data_sync ? S_IDLE : S_WAIT_IDLE;
      end
      S_WAIT_IDLE: if (line_idle || timeout) state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  // Frame, bit index and shared cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr     <= '0;
      bit_idx <= '0;
      frame   <= '0;
    end else begin
      if (accept) begin
        frame <= {1'b1, ~^cmd.cmd_data, cmd.cmd_data};
      end
      case (state)
        S_INHIBIT: tmr <= inh_last ? '0 : tmr + 1'b1;
        S_RTS, S_SEND, S_ACK, S_WAIT_IDLE:
          tmr <= (fall || state_nx == S_IDLE) ? '0 : tmr + 1'b1;
        default:   tmr <= '0;
      endcase
      if (state == S_SEND && fall) begin
        bit_idx <= bit_idx + 1'b1;
      end else if (state != S_SEND) begin
        bit_idx <= '0;
      end
    end
  end

  // Output logic; a timeout releases both lines in the same cycle as err.
  always_comb begin
    ps2_clk_oe    = 1'b0;
    ps2_data_oe   = 1'b0;
    cmd.cmd_ready = (state == S_IDLE);
    cmd.busy      = (state != S_IDLE);
    cmd.done      = (state == S_WAIT_IDLE) && line_idle;
    cmd.err       = timeout | nack;
    case (state)
      S_INHIBIT: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = inh_last;
      end
      S_RTS:     ps2_data_oe = ~timeout;
      S_SEND:    ps2_data_oe = ~frame[bit_idx] & ~timeout;
      default: begin
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;
  localparam int INH  = 20;
  localparam int TMO  = 500;
  localparam int HALF = 40;

  typedef struct {
    logic [7:0] cmd;
    bit         ack;
    logic       exp_par;
    int         exp_done;
    int         exp_err;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         done_n;
    int         err_n;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk_oe;
  logic ps2_data_oe;
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  wire  ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
  wire  ps2_data_i = ~(ps2_data_oe | dev_data_low);

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int inh_run = 0;
  int inh_len = 0;
  int inh_runs = 0;
  int inh_data_cyc = 0;
  int inh_data_pos = 0;
  exp_t sb[$];

  ps2_host_tx_if cmd_if ();

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd_if),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  // Pulse counters and inhibit-interval measurement
  always @(negedge clk) begin
    if (cmd_if.done === 1'b1) done_cnt++;
    if (cmd_if.err === 1'b1) err_cnt++;
    if (cmd_if.done === 1'b1 && cmd_if.err === 1'b1) both_cnt++;
    if (ps2_clk_oe === 1'b1) begin
      inh_run++;
      if (ps2_data_oe === 1'b1) begin
        inh_data_cyc++;
        inh_data_pos = inh_run;
      end
    end else if (inh_run != 0) begin
      inh_len = inh_run;
      inh_runs++;
      inh_run = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    cmd_if.cmd_data  = b;
    cmd_if.cmd_valid = 1'b1;
    check("ready_before_accept", cmd_if.cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    check("ready_low_after_accept", cmd_if.cmd_ready, 0);
  endtask

  task automatic dev_wait_rts(output bit ok);
    int t = 0;
    while (!(ps2_clk_i === 1'b1 && ps2_data_i === 1'b0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    ok = (t < 2000);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL rts_wait actual=timeout expected=rts");
    end
  endtask

  task automatic dev_bit(output logic b);
    @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    b = ps2_data_i;
    dev_clk_low = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic device_txn(input bit ack, output logic [7:0] got, output logic par,
                            output logic stp, output logic start, output bit ok);
    logic b;
    got   = '0;
    par   = 1'b0;
    stp   = 1'b0;
    start = 1'b1;
    dev_wait_rts(ok);
    if (!ok) return;
    repeat (HALF) @(negedge clk);
    start = ps2_data_i;
    for (int i = 0; i < 8; i++) begin
      dev_bit(b);
      got[i] = b;
    end
    dev_bit(par);
    dev_bit(stp);
    dev_data_low = ack;
    repeat (HALF / 2) @(negedge clk);
    dev_bit(b);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_result(input int d0, input int e0, output int dd, output int de);
    int t = 0;
    while ((done_cnt + err_cnt) == (d0 + e0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      checks++;
      errors++;
      $display("FAIL result_wait actual=timeout expected=done_or_err");
    end
    repeat (10) @(negedge clk);
    dd = done_cnt - d0;
    de = err_cnt - e0;
  endtask

  initial begin
    vec_t       vecs[4];
    exp_t       e;
    logic [7:0] got;
    logic       par, stp, start, b;
    bit         ok;
    int         d0, e0, dd, de, r0, t, n;

    vecs[0] = '{cmd: 8'hED, ack: 1'b1, exp_par: 1'b1, exp_done: 1, exp_err: 0};
    vecs[1] = '{cmd: 8'h01, ack: 1'b1, exp_par: 1'b0, exp_done: 1, exp_err: 0};
    vecs[2] = '{cmd: 8'hFF, ack: 1'b1, exp_par: 1'b1, exp_done: 1, exp_err: 0};
    vecs[3] = '{cmd: 8'hA5, ack: 1'b0, exp_par: 1'b1, exp_done: 0, exp_err: 1};

    cmd_if.cmd_data  = 8'h00;
    cmd_if.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_ready", cmd_if.cmd_ready, 1);
    check("rst_busy", cmd_if.busy, 0);
    check("rst_done", cmd_if.done, 0);
    check("rst_err", cmd_if.err, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Table-driven transfers: ACK'd commands and one NACK
    for (int i = 0; i < 4; i++) begin
      inh_data_cyc = 0;
      inh_data_pos = 0;
      d0 = done_cnt;
      e0 = err_cnt;
      sb.push_back('{data: vecs[i].cmd, par: vecs[i].exp_par,
                     done_n: vecs[i].exp_done, err_n: vecs[i].exp_err});
      send_cmd(vecs[i].cmd);
      device_txn(vecs[i].ack, got, par, stp, start, ok);
      wait_result(d0, e0, dd, de);
      e = sb.pop_front();
      if (ok) begin
        check("start_bit", start, 0);
        check("byte", got, e.data);
        check("parity", par, e.par);
        check("stop_bit", stp, 1);
      end
      check("done_pulses", dd, e.done_n);
      check("err_pulses", de, e.err_n);
      check("done_err_overlap", both_cnt, 0);
      check("inhibit_len", inh_len, INH);
      check("inhibit_data_cycles", inh_data_cyc, 1);
      check("inhibit_data_pos", inh_data_pos, INH);
      check("ready_after", cmd_if.cmd_ready, 1);
      check("clk_oe_after", ps2_clk_oe, 0);
      check("data_oe_after", ps2_data_oe, 0);
    end

    // Device never clocks: err exactly TMO cycles after RTS entry
    d0 = done_cnt;
    e0 = err_cnt;
    send_cmd(8'h3C);
    t = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("timeout_rts_reached", (t < 200), 1);
    n = 0;
    while (cmd_if.err !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", n, TMO);
    check("timeout_clk_oe", ps2_clk_oe, 0);
    check("timeout_data_oe", ps2_data_oe, 0);
    @(negedge clk);
    check("timeout_ready", cmd_if.cmd_ready, 1);
    repeat (10) @(negedge clk);
    check("timeout_err_pulses", err_cnt - e0, 1);
    check("timeout_done_pulses", done_cnt - d0, 0);

    // Reset in the middle of the data bits
    d0 = done_cnt;
    e0 = err_cnt;
    send_cmd(8'hED);
    dev_wait_rts(ok);
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 5; i++) dev_bit(b);
    check("pre_rst_data_drive", ps2_data_oe, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_clk_oe", ps2_clk_oe, 0);
    check("rst_mid_data_oe", ps2_data_oe, 0);
    check("rst_mid_ready", cmd_if.cmd_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_mid_done", done_cnt - d0, 0);
    check("rst_mid_err", err_cnt - e0, 0);
    d0 = done_cnt;
    e0 = err_cnt;
    sb.push_back('{data: 8'hF4, par: 1'b0, done_n: 1, err_n: 0});
    send_cmd(8'hF4);
    device_txn(1'b1, got, par, stp, start, ok);
    wait_result(d0, e0, dd, de);
    e = sb.pop_front();
    check("post_rst_byte", got, e.data);
    check("post_rst_parity", par, e.par);
    check("post_rst_done", dd, e.done_n);
    check("post_rst_err", de, e.err_n);

    // cmd_valid during SEND is ignored
    d0 = done_cnt;
    e0 = err_cnt;
    r0 = inh_runs;
    sb.push_back('{data: 8'hED, par: 1'b1, done_n: 1, err_n: 0});
    send_cmd(8'hED);
    fork
      device_txn(1'b1, got, par, stp, start, ok);
      begin
        int w = 0;
        while (ps2_clk_oe === 1'b1 && w < 200) begin
          @(negedge clk);
          w++;
        end
        repeat (200) @(negedge clk);
        cmd_if.cmd_data  = 8'h55;
        cmd_if.cmd_valid = 1'b1;
        check("busy_during_send", cmd_if.busy, 1);
        check("ready_during_send", cmd_if.cmd_ready, 0);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
      end
    join
    wait_result(d0, e0, dd, de);
    repeat (200) @(negedge clk);
    e = sb.pop_front();
    check("ignored_byte", got, e.data);
    check("ignored_done", done_cnt - d0, e.done_n);
    check("ignored_err", err_cnt - e0, e.err_n);
    check("ignored_inhibits", inh_runs - r0, 1);
    check("ignored_idle_clk", ps2_clk_oe, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
